// File: rtl/bg_mem_arbiter.sv
// Single-port background BRAM arbiter: display reads always win inside the map window,
// and the tile-erase engine writes only while the display is outside it.
module bg_mem_arbiter #(
  parameter int unsigned ROW_W    = 320,
  parameter int unsigned ROW_H    = 170,
  parameter int unsigned V_OFFSET = 30,
  parameter int unsigned TILE     = 4,
  parameter int unsigned DATA_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              disp_valid,
  input  logic              erase_req,
  input  logic [8:0]        erase_x,
  input  logic [7:0]        erase_y,
  input  logic [DATA_W-1:0] erase_color,
  output logic              erase_ack,
  output logic              erase_busy,
  output logic              erase_done,
  output logic [15:0]       mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din
);

  localparam int unsigned   CntW    = (TILE > 1) ? $clog2(TILE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TILE - 1);
  localparam logic [9:0]    HMax    = 10'd640;
  localparam logic [9:0]    WinVLo  = 10'(V_OFFSET);
  localparam logic [9:0]    WinVHi  = 10'(V_OFFSET + 2 * ROW_H);
  localparam logic [16:0]   RowW    = 17'(ROW_W);
  localparam logic [16:0]   RowH    = 17'(ROW_H);

  typedef enum logic [1:0] {StIdle, StWait, StWrite, StDone} state_e;

  state_e              state_q, state_d;
  logic [8:0]          x_q, x_d;
  logic [7:0]          y_q, y_d;
  logic [DATA_W-1:0]   color_q, color_d;
  logic [CntW-1:0]     i_q, i_d, j_q, j_d;
  logic                ack_q, ack_d;
  logic [15:0]         addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   din_q, din_d;

  logic                win;
  logic [9:0]          v_rel;
  logic [15:0]         rd_addr;
  logic [16:0]         px, py;
  logic [15:0]         wr_addr;

  assign win     = disp_valid && (h_cnt < HMax) && (v_cnt >= WinVLo) && (v_cnt < WinVHi);
  assign v_rel   = v_cnt - WinVLo;
  assign rd_addr = 16'(17'(h_cnt >> 1) + RowW * 17'(v_rel >> 1));

  // Pixel coordinates kept 17 bits wide so clipped positions compare correctly.
  assign px      = 17'(x_q) + 17'(i_q);
  assign py      = 17'(y_q) + 17'(j_q);
  assign wr_addr = 16'(px + RowW * py);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    i_d     = i_q;
    j_d     = j_q;
    ack_d   = 1'b0;
    addr_d  = 16'd0;
    we_d    = 1'b0;
    din_d   = din_q;

    if (win) begin
      addr_d = rd_addr;
    end

    unique case (state_q)
      StIdle: begin
        if (erase_req) begin
          x_d     = erase_x;
          y_d     = erase_y;
          color_d = erase_color;
          i_d     = '0;
          j_d     = '0;
          ack_d   = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (!win) state_d = StWrite;
      end
      StWrite: begin
        // A read in the window preempts the pending pixel; counters hold for the retry.
        if (win) begin
          state_d = StWait;
        end else begin
          addr_d = wr_addr;
          din_d  = color_q;
          we_d   = (px < RowW) && (py < RowH);
          if (i_q == CntLast) begin
            i_d = '0;
            if (j_q == CntLast) begin
              j_d     = '0;
              state_d = StDone;
            end else begin
              j_d = j_q + 1'b1;
            end
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      i_q     <= '0;
      j_q     <= '0;
      ack_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
      i_q     <= i_d;
      j_q     <= j_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      din_q   <= din_d;
    end
  end

  assign erase_ack  = ack_q;
  assign erase_busy = (state_q == StWait) || (state_q == StWrite);
  assign erase_done = (state_q == StDone);
  assign mem_addr   = addr_q;
  assign mem_we     = we_q;
  assign mem_din    = din_q;

endmodule

// File: tb/tb_bg_mem_arbiter.sv
// Directed bench for bg_mem_arbiter: reset, display addressing, tile erase, pause/resume,
// clipping, busy rejection, re-acceptance and mid-tile reset.
module tb_bg_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h_cnt, v_cnt;
  logic        disp_valid;
  logic        erase_req;
  logic [8:0]  erase_x;
  logic [7:0]  erase_y;
  logic [11:0] erase_color;
  logic        erase_ack, erase_busy, erase_done;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_din;

  int checks   = 0;
  int failures = 0;

  logic [16:0] exp_addr[16];
  int          exp_n;

  always #5 clk = ~clk;

  bg_mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .disp_valid (disp_valid),
    .erase_req  (erase_req),
    .erase_x    (erase_x),
    .erase_y    (erase_y),
    .erase_color(erase_color),
    .erase_ack  (erase_ack),
    .erase_busy (erase_busy),
    .erase_done (erase_done),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_din    (mem_din)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_full_tile(input int base);
    for (int k = 0; k < 16; k++) exp_addr[k] = 17'(base + (k % 4) + 320 * (k / 4));
    exp_n = 16;
  endtask

  // Requests a tile, then follows it to its done pulse, checking every write against exp_addr.
  task automatic run_tile(input logic [8:0] x, input logic [7:0] y, input logic [11:0] col,
                          input int pause_at, input int pause_len, input bit reject,
                          output int cycles);
    int nw       = 0;
    int paused   = 0;
    bit in_win   = 0;
    bit got_done = 0;
    erase_x     = x;
    erase_y     = y;
    erase_color = col;
    erase_req   = 1'b1;
    step();
    check("ack", erase_ack, 1);
    check("busy_at_ack", erase_busy, 1);
    if (reject) begin
      erase_x     = 9'd100;
      erase_y     = 8'd50;
      erase_color = 12'hFFF;
    end else begin
      erase_req = 1'b0;
    end
    cycles = 0;
    for (int c = 0; c < 80 && !got_done; c++) begin
      step();
      cycles++;
      if (in_win) begin
        check("paused_we", mem_we, 0);
        check("paused_addr", mem_addr, 50);
      end
      if (reject) check("reject_ack", erase_ack, 0);
      if (mem_we) begin
        if (nw < exp_n) check("wr_addr", mem_addr, exp_addr[nw]);
        check("wr_din", mem_din, col);
        nw++;
      end
      if (erase_done) begin
        got_done = 1;
        check("busy_at_done", erase_busy, 0);
      end else begin
        check("busy_mid", erase_busy, 1);
      end
      in_win = (pause_len > 0) && (nw >= pause_at) && (paused < pause_len);
      if (in_win) paused++;
      disp_valid = in_win;
      h_cnt      = in_win ? 10'd100 : 10'd700;
      v_cnt      = in_win ? 10'd31 : 10'd400;
    end
    check("done_seen", got_done, 1);
    check("write_count", nw, exp_n);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  cyc;
    int  nw;
    bit  saw_done;
    bit  saw_we;

    rst         = 1'b1;
    erase_req   = 1'b1;
    erase_x     = 9'd10;
    erase_y     = 8'd20;
    erase_color = 12'h000;
    disp_valid  = 1'b0;
    h_cnt       = 10'd700;
    v_cnt       = 10'd400;

    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_ack", erase_ack, 0);
      check("rst_busy", erase_busy, 0);
      check("rst_done", erase_done, 0);
      check("rst_we", mem_we, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_din", mem_din, 0);
    end
    rst = 1'b0;

    // Blanking erase directly after reset release: ack on the first cycle.
    fill_full_tile(6410);
    run_tile(9'd10, 8'd20, 12'h000, 0, 0, 0, cyc);
    check("blank_cycles", cyc, 17);
    step();
    check("idle_we", mem_we, 0);
    check("idle_busy", erase_busy, 0);
    check("idle_done", erase_done, 0);

    // Display addressing and window edges.
    disp_valid = 1'b1; h_cnt = 10'd100; v_cnt = 10'd31;
    step(); check("disp_100_31", mem_addr, 50); check("disp_we", mem_we, 0);
    h_cnt = 10'd639; v_cnt = 10'd369;
    step(); check("disp_639_369", mem_addr, 54399);
    h_cnt = 10'd3; v_cnt = 10'd32;
    step(); check("disp_3_32", mem_addr, 321);
    h_cnt = 10'd100; v_cnt = 10'd370;
    step(); check("disp_v370", mem_addr, 0);
    v_cnt = 10'd29;
    step(); check("disp_v29", mem_addr, 0);
    h_cnt = 10'd640; v_cnt = 10'd100;
    step(); check("disp_h640", mem_addr, 0);
    disp_valid = 1'b0; h_cnt = 10'd100; v_cnt = 10'd31;
    step(); check("disp_invalid", mem_addr, 0);
    h_cnt = 10'd700; v_cnt = 10'd400;
    step();

    // Pause after 3 writes for 4 window cycles; costs 5 extra cycles, no lost or repeated pixel.
    fill_full_tile(6410);
    run_tile(9'd10, 8'd20, 12'h5A5, 3, 4, 0, cyc);
    check("pause_cycles", cyc, 22);
    step();

    // Clipped corner tile: only 4 in-range pixels written.
    exp_addr[0] = 17'd54078;
    exp_addr[1] = 17'd54079;
    exp_addr[2] = 17'd54398;
    exp_addr[3] = 17'd54399;
    exp_n       = 4;
    run_tile(9'd318, 8'd168, 12'h3C3, 0, 0, 0, cyc);
    check("clip_cycles", cyc, 17);
    step();

    // Second request held during busy: ignored, then accepted right after DONE.
    fill_full_tile(6410);
    run_tile(9'd10, 8'd20, 12'h123, 0, 0, 1, cyc);
    step();
    check("reaccept_wait", erase_ack, 0);
    step();
    check("reaccept_ack", erase_ack, 1);
    erase_req = 1'b0;

    // Reset after 5 writes of the re-accepted tile.
    nw = 0;
    for (int c = 0; c < 30 && nw < 5; c++) begin
      step();
      if (mem_we) begin
        if (nw == 0) check("reaccept_din", mem_din, 12'hFFF);
        nw++;
      end
    end
    check("pre_rst_writes", nw, 5);
    rst = 1'b1;
    step();
    check("midrst_we", mem_we, 0);
    check("midrst_busy", erase_busy, 0);
    check("midrst_done", erase_done, 0);
    check("midrst_addr", mem_addr, 0);
    rst      = 1'b0;
    saw_done = 0;
    saw_we   = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (erase_done) saw_done = 1;
      if (mem_we) saw_we = 1;
    end
    check("post_rst_no_done", saw_done, 0);
    check("post_rst_no_we", saw_we, 0);
    check("post_rst_busy", erase_busy, 0);

    fill_full_tile(6410);
    run_tile(9'd10, 8'd20, 12'h0F0, 0, 0, 0, cyc);
    check("post_rst_cycles", cyc, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
